packet_gen: RTL
===============

# packet_gen

Streaming packet generator that consumes the configuration outputs of the packet-config block (length, count, idle gap, initial value, start strobe) and emits packets of incrementing 16-bit values on a 512-bit AXI-Stream master toward the 100GbE MAC TX path. It reports `busy` back to the config block, which refuses register writes while busy is high. It is the transmit-side counterpart to the config block's control interface.

## Interface
Parameters:
- `DW`, 512, stream data width in bits; multiple of 16; `DW/8` tkeep bits, `DW/16` lanes.

Ports:
- `clk`  in  1  sole clock; one clock, all logic in this domain.
- `reset`  in  1  asynchronous, active-high reset.
- `packet_len`  in  16  packet length in bytes, 1..9600; sampled only on `start`.
- `packet_count`  in  32  packets to send; sampled only on `start`.
- `idle_cycles`  in  16  tvalid-low cycles between packets; sampled only on `start`.
- `initial_value`  in  16  value of lane 0 of the first beat; sampled only on `start`.
- `start`  in  1  single-cycle strobe that begins a run.
- `busy`  out  1  high from the cycle after an accepted start until the run ends.
- `packets_sent`  out  32  packets completed in the current or most recent run.
- `axis_tdata`  out  DW  lane i (bits 16i+15:16i) = current value + i, mod 2^16.
- `axis_tkeep`  out  DW/8  byte enables.
- `axis_tlast`  out  1  last beat of packet.
- `axis_tvalid`  out  1  beat valid.
- `axis_tready`  in  1  downstream ready.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: when `start`=1 and the latched `packet_count` value is nonzero, latch all four config inputs, load value = `initial_value`, beats_left = ceil(len/64), pkts_left = count, clear `packets_sent`, and enter SEND. `start` with count 0 is ignored. `start` outside IDLE is ignored.
- SEND: `axis_tvalid`=1. On each handshake (tvalid&tready):
  - value += DW/16 on full beats.
  - On the last beat, value += ceil(bytes_in_last_beat/2).
  - beats_left decrements.
- Beat rules:
  - tkeep is all-ones except on the last beat, where the low (len mod 64) bits are set, or all bits if len mod 64 = 0.
  - tlast=1 only on the last beat.
  - Unused lanes of the last beat still carry value+i; only tkeep masks them.
- Last-beat handshake:
  - `packets_sent` increments and pkts_left decrements.
  - If pkts_left becomes 0, go to IDLE.
  - Otherwise, if idle_cycles=0, stay in SEND with reloaded beats_left (back-to-back packets).
  - Otherwise go to GAP with gap counter = idle_cycles.
- GAP: `axis_tvalid`=0. Decrement the gap counter each cycle. At 1, return to SEND.
- Value sequence is continuous across packets within a run and wraps mod 2^16.
- AXI-Stream rule: while tvalid=1 and tready=0, tdata, tkeep and tlast hold stable and tvalid is not withdrawn.
- `busy` = (state != IDLE), registered.
- Reset mid-run: all state and outputs clear immediately (asynchronous). The packet in flight is truncated without tlast; downstream must tolerate this.
- Reset values: `busy`=0, `packets_sent`=0, `axis_tvalid`=0, `axis_tlast`=0, `axis_tkeep`=0, `axis_tdata`=0; state IDLE.

## Timing
- `start` sampled at edge N → `busy`=1 and first beat valid (tvalid=1) from edge N, visible in cycle N+1.
- With tready held high, throughput is one beat per clock.
- Gap: last beat accepted at edge T → tvalid low for exactly idle_cycles cycles → next first beat valid after edge T+idle_cycles.
- Final packet: last beat accepted at edge T → `busy`=0 and tvalid=0 after edge T. There is no trailing gap.
- `packets_sent` updates on the same edge as the tlast handshake.

## Structure
- Package `packet_gen_pkg` holds:
  - the state encoding (IDLE/SEND/GAP);
  - the bytes-per-beat constant 64;
  - MAX_PACKET_LEN = 9600.
- One natural sub-module, `packet_gen_beat`. It is combinational and:
  - builds tdata from the value;
  - builds tkeep/tlast from beats_left and len mod 64;
  - computes the value increment.
- The top level holds the FSM and counters.

## Test plan
- **Single short packet:** len=10, count=1, init=0x0100, tready=1 → one beat:
  - tkeep=0x3FF, tlast=1;
  - lane0=0x0100, lane4=0x0104;
  - busy high for exactly 1 cycle;
  - packets_sent=1.
- **Back-to-back packets:** len=130, count=3, idle=0 → 9 beats on consecutive cycles.
  - Every third beat has tlast and tkeep=0x3.
  - Packet 2 lane0 = init+65.
  - tvalid never drops.
- **Idle gap:** len=64, count=2, idle=5 → tvalid low for exactly 5 cycles between the two tlast beats.
  - Packet 2 lane0 = init+32.
- **Backpressure:** len=256, count=1, tready toggling 1-0-0-1 → tdata/tkeep/tlast stable during stalls.
  - Exactly 4 beats accepted, lane0 of each = init, +32, +64, +96.
- **Ignored starts and wrap:**
  - start with count=0 → busy stays 0.
  - start during a run → no effect.
  - init=0xFFF0 → lane 16 of beat 0 = 0x0000.
- **Reset mid-run:** assert reset during beat 2 of a len=9600 packet → tvalid, busy and packets_sent are 0 immediately.
  - After release, a new start runs cleanly from its own init value.

Source files
------------

// File: rtl/packet_gen_pkg.sv
// packet_gen_pkg: shared FSM encoding and framing constants for the packet generator
package packet_gen_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam int BYTES_PER_BEAT = 64;
  localparam int MAX_PACKET_LEN = 9600;
endpackage

// File: rtl/packet_gen_beat.sv
// packet_gen_beat: combinational beat builder (value -> tdata/tkeep/tlast, next-value increment)
module packet_gen_beat
  import packet_gen_pkg::*;
#(
  parameter int DW = BYTES_PER_BEAT * 8
) (
  input  logic [15:0]     value,
  input  logic [15:0]     beats_left,
  input  logic [15:0]     len_mod,
  output logic [DW-1:0]   data,
  output logic [DW/8-1:0] keep,
  output logic            last,
  output logic [15:0]     inc
);
  localparam int BPB = DW / 8;
  localparam int LANES = DW / 16;
  logic partial;
  assign last = beats_left == 16'd1;
  assign partial = last && len_mod != 16'd0;
  assign keep = partial ? {BPB{1'b1}} >> (BPB - int'(len_mod)) : {BPB{1'b1}};
  assign inc = partial ? (len_mod + 16'd1) >> 1 : 16'(LANES);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign data[16*i +: 16] = value + 16'(i);
  end
endmodule

// File: rtl/packet_gen.sv
// packet_gen: streaming generator of incrementing-value packets on an AXI-Stream master
module packet_gen
  import packet_gen_pkg::*;
#(
  parameter int DW = BYTES_PER_BEAT * 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     packet_len,
  input  logic [31:0]     packet_count,
  input  logic [15:0]     idle_cycles,
  input  logic [15:0]     initial_value,
  input  logic            start,
  output logic            busy,
  output logic [31:0]     packets_sent,
  output logic [DW-1:0]   axis_tdata,
  output logic [DW/8-1:0] axis_tkeep,
  output logic            axis_tlast,
  output logic            axis_tvalid,
  input  logic            axis_tready
);
  localparam int BPB = DW / 8;
  logic [1:0] state;
  logic [15:0] value, beats_left, beats_reload, len_mod, idle_r, gap_cnt, len_eff, inc;
  logic [31:0] pkts_left;
  logic [DW-1:0] data;
  logic [DW/8-1:0] keep;
  logic last, send;
  assign len_eff = packet_len == 16'd0 ? 16'd1 :
                   packet_len > 16'(MAX_PACKET_LEN) ? 16'(MAX_PACKET_LEN) : packet_len;
  packet_gen_beat #(.DW(DW)) u_beat (
    .value(value), .beats_left(beats_left), .len_mod(len_mod),
    .data(data), .keep(keep), .last(last), .inc(inc)
  );
  assign send = state == ST_SEND;
  assign busy = state != ST_IDLE;
  assign axis_tvalid = send;
  assign axis_tdata = send ? data : '0;
  assign axis_tkeep = send ? keep : '0;
  assign axis_tlast = send && last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      value <= '0;
      beats_left <= '0;
      beats_reload <= '0;
      len_mod <= '0;
      idle_r <= '0;
      gap_cnt <= '0;
      pkts_left <= '0;
      packets_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start && packet_count != 32'd0) begin
          state <= ST_SEND;
          value <= initial_value;
          beats_left <= 16'((32'(len_eff) + 32'(BPB) - 32'd1) / 32'(BPB));
          beats_reload <= 16'((32'(len_eff) + 32'(BPB) - 32'd1) / 32'(BPB));
          len_mod <= 16'(32'(len_eff) % 32'(BPB));
          idle_r <= idle_cycles;
          pkts_left <= packet_count;
          packets_sent <= '0;
        end
        ST_SEND: if (axis_tready) begin
          value <= value + inc;
          beats_left <= last ? beats_reload : beats_left - 16'd1;
          if (last) begin
            packets_sent <= packets_sent + 32'd1;
            pkts_left <= pkts_left - 32'd1;
            gap_cnt <= idle_r;
            state <= pkts_left == 32'd1 ? ST_IDLE : idle_r == 16'd0 ? ST_SEND : ST_GAP;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt == 16'd1) state <= ST_SEND;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
